// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: opcodes, FSM states, latency limits.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_t;

  localparam int unsigned MUL_LATENCY_MIN = 1;
  localparam int unsigned MUL_LATENCY_MAX = 4;

endpackage

// File: rtl/div_iter.sv
// Unsigned radix-2 restoring divider core: one quotient bit per step, last_o flags the final step.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             last_o
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_sh, diff;

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = CW'(WIDTH - 1);
    end else if (step_i) begin
      // quo_q doubles as the dividend shift register; its MSB feeds the partial remainder
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign last_o      = (cnt_q == '0);

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO owner: pipelined MULT/MULTU, iterative DIV/DIVU, MTHI/MTLO.
//   state | meaning
//   IDLE  | accepting start; MTHI/MTLO complete here
//   MUL   | product travelling down the pipeline
//   DIV   | one quotient bit per cycle
//   FIX   | apply signs (or divide-by-zero result) and write HI/LO
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clock_enable,
  input  logic             start,
  input  op_t              op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int LAT = (MUL_LATENCY < int'(MUL_LATENCY_MIN)) ? int'(MUL_LATENCY_MIN) :
                       (MUL_LATENCY > int'(MUL_LATENCY_MAX)) ? int'(MUL_LATENCY_MAX) : MUL_LATENCY;
  localparam logic [1:0] MUL_CNT_INIT = 2'(LAT - 1);

  state_t           state_q, state_d;
  logic [1:0]       mul_cnt_q, mul_cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, dvd_q, dvd_d;
  logic             done_q, done_d, dz_q, dz_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [2*WIDTH-1:0] pipe_q [LAT];
  logic               mul_sgn, div_sgn, div_load, div_step, div_last;
  logic [WIDTH-1:0]   mag_a, mag_b, div_quo, div_rem;

  always_comb begin
    mul_sgn = (op == OP_MULT);
    div_sgn = (op == OP_DIV);
    ext_a   = {{WIDTH{mul_sgn & operand_a[WIDTH-1]}}, operand_a};
    ext_b   = {{WIDTH{mul_sgn & operand_b[WIDTH-1]}}, operand_b};
    prod    = ext_a * ext_b;
    mag_a   = (div_sgn && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    mag_b   = (div_sgn && operand_b[WIDTH-1]) ? -operand_b : operand_b;
  end

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk_i       (clk),
    .reset_i     (reset),
    .en_i        (clock_enable),
    .load_i      (div_load),
    .step_i      (div_step),
    .dividend_i  (mag_a),
    .divisor_i   (mag_b),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .last_o      (div_last)
  );

  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dvd_d     = dvd_q;
    dz_d      = dz_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    done_d    = 1'b0;
    div_load  = 1'b0;
    div_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dz_d = 1'b0;
          case (op)
            OP_MULT, OP_MULTU: begin
              state_d   = ST_MUL;
              mul_cnt_d = MUL_CNT_INIT;
            end
            OP_DIV, OP_DIVU: begin
              if (operand_b == '0) begin
                dz_d    = 1'b1;
                dvd_d   = operand_a;
                state_d = ST_FIX;
              end else begin
                div_load = 1'b1;
                q_neg_d  = div_sgn & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                r_neg_d  = div_sgn & operand_a[WIDTH-1];
                state_d  = ST_DIV;
              end
            end
            OP_MTHI: hi_d = operand_a;
            OP_MTLO: lo_d = operand_a;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (mul_cnt_q == 2'd0) begin
          hi_d    = pipe_q[LAT-1][2*WIDTH-1:WIDTH];
          lo_d    = pipe_q[LAT-1][WIDTH-1:0];
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          mul_cnt_d = mul_cnt_q - 2'd1;
        end
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (div_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        // dz_q can only be set here by the divide-by-zero issue that led to FIX
        if (dz_q) begin
          hi_d = dvd_q;
          lo_d = '1;
        end else begin
          lo_d = q_neg_q ? -div_quo : div_quo;
          hi_d = r_neg_q ? -div_rem : div_rem;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mul_cnt_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dvd_q     <= '0;
      dz_q      <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      done_q    <= 1'b0;
      for (int k = 0; k < LAT; k++) pipe_q[k] <= '0;
    end else if (clock_enable) begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dvd_q     <= dvd_d;
      dz_q      <= dz_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      done_q    <= done_d;
      pipe_q[0] <= prod;
      for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32, MUL_LATENCY=2) with hand-computed results.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W   = 32;
  localparam int LIM = 200;

  logic         clk = 1'b0;
  logic         reset, clock_enable, start;
  op_t          op;
  logic [W-1:0] operand_a, operand_b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;
  int n;
  bit chg, seen;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .MUL_LATENCY(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .clock_enable (clock_enable),
    .start        (start),
    .op           (op),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .busy         (busy),
    .done         (done),
    .div_by_zero  (div_by_zero),
    .hi           (hi),
    .lo           (lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    tick();
    start     = 1'b0;
  endtask

  // counts busy cycles after issue and flags any HI/LO change while busy
  task automatic run(output int cycles, output bit changed);
    logic [W-1:0] oh, ol;
    oh = hi;
    ol = lo;
    cycles  = 0;
    changed = 1'b0;
    while (busy && cycles < LIM) begin
      if (hi !== oh || lo !== ol) changed = 1'b1;
      cycles++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; clock_enable = 1'b1; start = 1'b0;
    op = OP_MULT; operand_a = '0; operand_b = '0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    reset = 1'b0;
    tick();

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    check("multu_busy_e0", busy, 1);
    run(n, chg);
    check("multu_cycles", n, 2);
    check("multu_stable", chg, 0);
    check("multu_done", done, 1);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);
    tick();
    check("multu_done_drop", done, 0);

    issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
    run(n, chg);
    check("mult_cycles", n, 2);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);
    tick();

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run(n, chg);
    check("div_cycles", n, 33);
    check("div_stable", chg, 0);
    check("div_done", done, 1);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_dz", div_by_zero, 0);
    tick();

    issue(OP_DIVU, 32'd5, 32'd0);
    run(n, chg);
    check("dz_cycles", n, 1);
    check("dz_done", done, 1);
    check("dz_hi", hi, 32'd5);
    check("dz_lo", lo, 32'hFFFF_FFFF);
    check("dz_flag", div_by_zero, 1);
    tick();
    check("dz_sticky", div_by_zero, 1);
    issue(OP_MTLO, 32'd7, 32'd0);
    check("mtlo_lo", lo, 32'd7);
    check("mtlo_hi", hi, 32'd5);
    check("mtlo_dz_clr", div_by_zero, 0);
    check("mtlo_busy", busy, 0);
    check("mtlo_done", done, 0);

    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo", lo, 32'd7);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run(n, chg);
    check("ovf_cycles", n, 33);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);
    check("ovf_dz", div_by_zero, 0);
    tick();

    issue(OP_DIVU, 32'd100, 32'd7);
    run(n, chg);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    tick();

    // start held while busy must not be taken
    issue(OP_MULTU, 32'd3, 32'd5);
    start = 1'b1; op = OP_MTHI; operand_a = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    check("ign_busy_e1", busy, 1);
    check("ign_hi_e1", hi, 32'd2);
    tick();
    check("ign_busy_e2", busy, 0);
    check("ign_done", done, 1);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd15);
    issue(OP_MTLO, 32'h55, 32'd0);
    check("b2b_lo", lo, 32'h55);
    tick();

    issue(OP_DIVU, 32'd100, 32'd7);
    n = 0;
    while (busy && n < LIM) begin
      n++;
      if (n == 4) clock_enable = 1'b0;
      if (n == 9) clock_enable = 1'b1;
      tick();
    end
    clock_enable = 1'b1;
    check("ce_cycles", n, 38);
    check("ce_done", done, 1);
    check("ce_lo", lo, 32'd14);
    check("ce_hi", hi, 32'd2);
    tick();

    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) tick();
    check("abort_busy_pre", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_done", done, 0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    check("abort_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit that owns the HI/LO architectural registers for the MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiply uses a configurable-latency pipelined product. Divide uses an iterative radix-2 restoring divider. The core datapath issues an operation with `start` and holds the pipeline on `busy` before any MFHI/MFLO or new HI/LO operation.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width; must be even and at least 8.
- `MUL_LATENCY`, 2, number of cycles from accepting a multiply to HI/LO being written; legal range 1–4.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `clock_enable`  in  1  when low, all state including counters and pipeline freezes.
- `start`  in  1  issue strobe; sampled only when `busy`=0.
- `op`  in  3  operation code from `muldiv_pkg::op_t`: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `operand_a`  in  WIDTH  rs value; dividend or multiplicand; source for MTHI/MTLO.
- `operand_b`  in  WIDTH  rt value; divisor or multiplier.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse on the cycle HI/LO are updated by a MULT*/DIV* operation.
- `div_by_zero`  out  1  sticky flag; set when a DIV/DIVU is issued with `operand_b`=0; cleared by the next accepted `start`.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- Reset values: `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0. The FSM returns to IDLE and the iteration counter is cleared.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE → MUL on `start` with MULT/MULTU.
  - IDLE → DIV on `start` with DIV/DIVU and nonzero divisor.
  - MUL → IDLE when the latency counter expires.
  - DIV → FIX after WIDTH iterations.
  - FIX → IDLE after one cycle.
- MTHI/MTLO: `hi` or `lo` is set to `operand_a` at the accepting edge. They do not assert `busy` or `done`.
- MULT/MULTU: the 2·WIDTH product is sign- or zero-extended per the op. HI gets the upper half and LO the lower half.
- DIV/DIVU:
  - Operands are latched at the accepting edge.
  - For signed ops, magnitudes are taken first. One quotient bit is produced per cycle.
  - FIX applies signs: the quotient truncates toward zero, and the remainder takes the sign of the dividend.
  - LO gets the quotient and HI gets the remainder.
- Divide by zero: no iteration. HI is set to the dividend and LO to all ones. `div_by_zero` is set, and `done` pulses on the next cycle.
- Signed overflow (−2^(WIDTH−1) ÷ −1): LO = −2^(WIDTH−1), HI = 0. No flag is raised.
- `start` while `busy`=1 is ignored with no side effects. The issuer must hold it.
- `hi`/`lo` keep their old values for the whole operation and change only on the `done` edge. This guarantees MFHI/MFLO never sees a partial result.
- Reset mid-operation aborts the operation. HI/LO are zeroed and `done` does not pulse.
- `clock_enable` low during an operation stretches the latency by the number of disabled cycles. Results are unchanged.

## Timing
- Cycles are counted from E0, the accepting edge.
- MULT*:
  - `busy`=1 from after E0 until E_MUL_LATENCY.
  - HI/LO are written at E_MUL_LATENCY.
  - `done`=1 for the cycle after that edge, which is also the cycle in which `busy` returns to 0.
- DIV*:
  - Iterations run at E1..E_WIDTH; FIX and the HI/LO write occur at E_(WIDTH+1).
  - `busy` is high for WIDTH+1 cycles.
  - `done` pulses in the cycle after E_(WIDTH+1).
- Divide by zero: `busy` high for 1 cycle; HI/LO written at E1.
- Back-to-back issue: a new `start` may be accepted in the same cycle `done`=1, because `busy` is already 0.
- No combinational path from `start` to `busy`. `busy` is a registered output.

## Structure
- Package `muldiv_pkg` holds:
  - `op_t` enum (3 bits);
  - `state_t` FSM enum;
  - localparam for the legal `MUL_LATENCY` range.
- Sub-module `div_iter`:
  - WIDTH-parametrised restoring divider core: remainder/quotient shift registers, a counter, and a `last` flag.
  - Unsigned only; sign handling stays in `muldiv_unit`.
- The multiply pipeline is an inline shift chain of product registers, depth `MUL_LATENCY`.

## Test plan
All scenarios use WIDTH=32 and MUL_LATENCY=2.
- MULTU with a=0xFFFFFFFF, b=2 → `done` 2 cycles after issue; HI=0x00000001, LO=0xFFFFFFFE.
- MULT with a=0xFFFFFFFF, b=2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE; `busy` is high for exactly 2 cycles.
- DIV with a=0xFFFFFFF9 (−7), b=2 → after 33 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; `hi`/`lo` are unchanged before `done`.
- DIVU with a=5, b=0 → HI=5, LO=0xFFFFFFFF, `div_by_zero`=1; next MTLO with a=7 → LO=7, flag cleared.
- DIV with a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- Start DIVU 100/7, then assert `reset` at cycle 10 → `busy`=0, HI=LO=0, no `done`. Also: `start` issued while busy is ignored; holding `clock_enable` low for 5 cycles extends `busy` by exactly 5 cycles.
